// File: rtl/aidc_lite_bit_packer.sv
// AIDC-Lite bit packer: packs variable-length code beats LSB-first into
// 64-bit buffer words, flushes the tail at end of block and reports size.
module aidc_lite_bit_packer #(
    parameter int ADDR_WIDTH = 3,
    parameter int IN_WIDTH   = 32,
    parameter int LEN_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [IN_WIDTH-1:0]   data_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic                  last_i,
    output logic                  wren_o,
    output logic [ADDR_WIDTH-1:0] waddr_o,
    output logic [63:0]           wdata_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH:0]   size_o,
    output logic                  overflow_o
);

    localparam int ACC_W  = 64 + IN_WIDTH;
    localparam int FILL_W = 7;
    localparam logic [FILL_W-1:0] WORD = FILL_W'(64);
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_PACK,
        S_FLUSH
    } state_t;

    state_t                state_q;
    logic [ACC_W-1:0]      acc_q;
    logic [FILL_W-1:0]     fill_q;
    logic [ADDR_WIDTH:0]   wptr_q;
    logic                  wren_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [63:0]           wdata_q;
    logic                  done_q;
    logic [ADDR_WIDTH:0]   size_q;
    logic                  ovf_q;

    logic [LEN_WIDTH-1:0]  len_sat;
    logic [IN_WIDTH-1:0]   mask;
    logic [ACC_W-1:0]      acc_d;
    logic [ACC_W-1:0]      acc_shift;
    logic [FILL_W-1:0]     fill_d;
    logic                  full;
    logic                  at_cap;
    logic [ADDR_WIDTH:0]   wptr_d;

    always_comb begin
        len_sat   = (len_i > LEN_WIDTH'(IN_WIDTH)) ? LEN_WIDTH'(IN_WIDTH) : len_i;
        mask      = ~({IN_WIDTH{1'b1}} << len_sat);
        acc_d     = acc_q | (ACC_W'(data_i & mask) << fill_q);
        acc_shift = acc_d >> 64;
        fill_d    = fill_q + FILL_W'(len_sat);
        full      = (fill_d >= WORD);
        at_cap    = (wptr_q == DEPTH);
        // Pointer parks at capacity so size saturates and never wraps.
        wptr_d    = at_cap ? wptr_q : wptr_q + (ADDR_WIDTH+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            fill_q  <= '0;
            wptr_q  <= '0;
            wren_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            size_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wren_q <= 1'b0;
            done_q <= 1'b0;
            if (start_i) begin
                state_q <= S_PACK;
                acc_q   <= '0;
                fill_q  <= '0;
                wptr_q  <= '0;
                size_q  <= '0;
                ovf_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                    end
                    S_PACK: begin
                        if (valid_i) begin
                            if (last_i && fill_d == '0) begin
                                done_q  <= 1'b1;
                                size_q  <= wptr_q;
                                state_q <= S_IDLE;
                            end else if (last_i || full) begin
                                if (at_cap) begin
                                    ovf_q <= 1'b1;
                                end else begin
                                    wren_q  <= 1'b1;
                                    waddr_q <= wptr_q[ADDR_WIDTH-1:0];
                                    wdata_q <= acc_d[63:0];
                                end
                                wptr_q <= wptr_d;
                                if (full) begin
                                    acc_q  <= acc_shift;
                                    fill_q <= fill_d - WORD;
                                end else begin
                                    acc_q  <= '0;
                                    fill_q <= '0;
                                end
                                if (last_i) begin
                                    if (fill_d > WORD) begin
                                        state_q <= S_FLUSH;
                                    end else begin
                                        done_q  <= 1'b1;
                                        size_q  <= wptr_d;
                                        state_q <= S_IDLE;
                                    end
                                end
                            end else begin
                                acc_q  <= acc_d;
                                fill_q <= fill_d;
                            end
                        end
                    end
                    S_FLUSH: begin
                        if (at_cap) begin
                            ovf_q <= 1'b1;
                        end else begin
                            wren_q  <= 1'b1;
                            waddr_q <= wptr_q[ADDR_WIDTH-1:0];
                            wdata_q <= acc_q[63:0];
                        end
                        wptr_q  <= wptr_d;
                        done_q  <= 1'b1;
                        size_q  <= wptr_d;
                        acc_q   <= '0;
                        fill_q  <= '0;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign ready_o    = (state_q == S_PACK);
    assign wren_o     = wren_q;
    assign waddr_o    = waddr_q;
    assign wdata_o    = wdata_q;
    assign done_o     = done_q;
    assign size_o     = size_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_aidc_lite_bit_packer.sv
// Directed bench for aidc_lite_bit_packer with a write/done event scoreboard.
module tb_aidc_lite_bit_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] data_i = '0;
    logic [5:0]  len_i = '0;
    logic        last_i = 1'b0;
    logic        wren_o;
    logic [2:0]  waddr_o;
    logic [63:0] wdata_o;
    logic        done_o;
    logic [3:0]  size_o;
    logic        overflow_o;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic        wr;
        logic [2:0]  addr;
        logic [63:0] data;
        logic        done;
        logic [3:0]  size;
    } ev_t;

    ev_t sb[$];

    aidc_lite_bit_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_i     (data_i),
        .len_i      (len_i),
        .last_i     (last_i),
        .wren_o     (wren_o),
        .waddr_o    (waddr_o),
        .wdata_o    (wdata_o),
        .done_o     (done_o),
        .size_o     (size_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic wr, input logic [2:0] a,
                        input logic [63:0] d, input logic dn,
                        input logic [3:0] sz);
        ev_t e;
        e.wr = wr; e.addr = a; e.data = d; e.done = dn; e.size = sz;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (wren_o || done_o) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_event wren=%b done=%b addr=%0d expected=none",
                       wren_o, done_o, waddr_o);
            end
            if (sb.size() != 0) begin
                ev_t e;
                e = sb.pop_front();
                check("ev_wren", 64'(wren_o), 64'(e.wr));
                check("ev_done", 64'(done_o), 64'(e.done));
                if (e.wr) begin
                    check("ev_addr", 64'(waddr_o), 64'(e.addr));
                    check("ev_data", wdata_o, e.data);
                end
                if (e.done) check("ev_size", 64'(size_o), 64'(e.size));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic [5:0] l,
                        input logic lst);
        valid_i = 1'b1; data_i = d; len_i = l; last_i = lst;
        tick();
        valid_i = 1'b0; last_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check(tag, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(ready_o), 64'd0);
        check({tag, "_wren"}, 64'(wren_o), 64'd0);
        check({tag, "_waddr"}, 64'(waddr_o), 64'd0);
        check({tag, "_wdata"}, wdata_o, 64'd0);
        check({tag, "_done"}, 64'(done_o), 64'd0);
        check({tag, "_size"}, 64'(size_o), 64'd0);
        check({tag, "_ovf"}, 64'(overflow_o), 64'd0);
    endtask

    initial begin
        logic [31:0] dk [1:20];

        // Reset with random inputs
        for (int i = 0; i < 5; i++) begin
            start_i = 1'($urandom); valid_i = 1'($urandom);
            data_i = $urandom; len_i = 6'($urandom_range(0, 32));
            last_i = 1'($urandom);
            @(negedge clk);
            check_reset_outputs("rst");
        end
        start_i = 1'b0; valid_i = 1'b1; last_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_rel_ready", 64'(ready_o), 64'd0);
        end
        valid_i = 1'b0;
        tick();

        // Aligned 32-bit beats
        for (int k = 1; k <= 8; k++) dk[k] = 32'h11111111 * k;
        for (int j = 0; j < 4; j++)
            push(1'b1, 3'(j), {dk[2*j+2], dk[2*j+1]}, j == 3, 4'd4);
        start();
        check("start_ready", 64'(ready_o), 64'd1);
        for (int k = 1; k <= 8; k++) beat(dk[k], 6'd32, k == 8);
        drain("aligned_drain");
        check("aligned_ovf", 64'(overflow_o), 64'd0);
        check("aligned_first", {dk[2], dk[1]}, 64'h2222222211111111);

        // Unaligned with flush; bits above len must be ignored
        push(1'b1, 3'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 4'd0);
        push(1'b1, 3'd1, 64'h000000000000003F, 1'b1, 4'd2);
        start();
        beat(32'hFFFFFFFF, 6'd20, 1'b0);
        beat(32'hFFFFFFFF, 6'd20, 1'b0);
        beat(32'hFFFFFFFF, 6'd20, 1'b0);
        beat(32'hFFFFFFFF, 6'd10, 1'b1);
        check("flush_ready", 64'(ready_o), 64'd0);
        drain("flush_drain");

        // Empty block
        push(1'b0, 3'd0, 64'd0, 1'b1, 4'd0);
        start();
        beat(32'hDEADBEEF, 6'd0, 1'b1);
        @(negedge clk);
        check("empty_done", 64'(done_o), 64'd1);
        drain("empty_drain");

        // Overflow
        for (int k = 1; k <= 20; k++) dk[k] = 32'h01010101 * k;
        for (int j = 0; j < 8; j++)
            push(1'b1, 3'(j), {dk[2*j+2], dk[2*j+1]}, 1'b0, 4'd0);
        push(1'b0, 3'd0, 64'd0, 1'b1, 4'd8);
        start();
        for (int k = 1; k <= 20; k++) begin
            beat(dk[k], 6'd32, k == 20);
            if (k == 17) check("ovf_before", 64'(overflow_o), 64'd0);
            if (k == 18) check("ovf_rise", 64'(overflow_o), 64'd1);
        end
        drain("ovf_drain");
        check("ovf_sticky", 64'(overflow_o), 64'd1);
        start();
        check("ovf_cleared", 64'(overflow_o), 64'd0);

        // Abort mid-block, beat presented with start is dropped
        push(1'b1, 3'd0, 64'hBBBBBBBBAAAAAAAA, 1'b0, 4'd0);
        beat(32'hAAAAAAAA, 6'd32, 1'b0);
        beat(32'hBBBBBBBB, 6'd32, 1'b0);
        beat(32'hCCCCCCCC, 6'd32, 1'b0);
        valid_i = 1'b1; data_i = 32'hEEEEEEEE; len_i = 6'd32; last_i = 1'b1;
        start();
        valid_i = 1'b0; last_i = 1'b0;
        push(1'b1, 3'd0, 64'h2222222211111111, 1'b1, 4'd1);
        beat(32'h11111111, 6'd32, 1'b0);
        beat(32'h22222222, 6'd32, 1'b1);
        drain("abort_drain");

        // Reset during FLUSH
        push(1'b1, 3'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 4'd0);
        start();
        beat(32'hFFFFFFFF, 6'd20, 1'b0);
        beat(32'hFFFFFFFF, 6'd20, 1'b0);
        beat(32'hFFFFFFFF, 6'd20, 1'b0);
        beat(32'hFFFFFFFF, 6'd10, 1'b1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_flush");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_flush_wren", 64'(wren_o), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_flush_ready", 64'(ready_o), 64'd0);
        drain("rst_flush_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
